// File: rtl/shift_register_tx_ctrl.sv
// Sequencer for a free-running parallel-load shift register.
// It accepts parallel words over a valid/ready handshake and drives the
// register's Load/D/Sin pins. It frames the register's serial output as a
// qualified MSB-first stream with a last-bit marker and a done pulse.
module shift_register_tx_ctrl #(
  parameter int   BW_DATA  = 8,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [BW_DATA-1:0] i_Data,
  input  logic               i_Valid,
  output logic               o_Ready,
  input  logic               i_Abort,
  output logic               o_Load,
  output logic [BW_DATA-1:0] o_D,
  output logic               o_Sin,
  input  logic               i_Sout,
  output logic               o_SerData,
  output logic               o_SerValid,
  output logic               o_SerLast,
  output logic               o_Done,
  output logic               o_Busy
);

  localparam int BW_CNT = $clog2(BW_DATA);
  localparam logic [BW_CNT-1:0] CNT_LAST = BW_CNT'(BW_DATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t              state_q;
  logic [BW_CNT-1:0]   cnt_q;
  logic [BW_DATA-1:0]  data_q;
  logic                done_q;

  logic                last_bit;
  logic                accept;

  // Handshake and stream framing decoded from the current state.
  // An abort masks the ready and stream qualifiers in the same cycle.
  always_comb begin
    last_bit   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    o_Ready    = ~i_Abort & ((state_q == IDLE) | last_bit);
    accept     = i_Valid & o_Ready;
    o_Load     = (state_q == LOAD);
    o_SerValid = (state_q == SHIFT) & ~i_Abort;
    o_SerLast  = last_bit & ~i_Abort;
    o_SerData  = i_Sout;
    o_Sin      = FILL_BIT;
    o_D        = data_q;
    o_Done     = done_q;
    o_Busy     = (state_q != IDLE);
  end

  // Sequencer: IDLE -> LOAD (one cycle) -> SHIFT (BW_DATA cycles).
  // The last bit cycle can chain straight into the next LOAD.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_Abort) begin
        // The word being sent is dropped. The held word stays on o_D.
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              data_q  <= i_Data;
              state_q <= LOAD;
            end
          end
          LOAD: begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
          SHIFT: begin
            cnt_q <= cnt_q + 1'b1;
            if (last_bit) begin
              done_q <= 1'b1;
              if (accept) begin
                data_q  <= i_Data;
                state_q <= LOAD;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_register_tx_ctrl.sv
// Bench for shift_register_tx_ctrl. Two controllers are used: one 8-bit with
// fill 0, and one 4-bit with fill 1. Each drives its own free-running shift
// register model. A cycle-indexed schedule of expected events predicts the
// outputs, and directed literal checks cover the model.
module tb_shift_register_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst;
  logic [7:0] data8;
  logic       v8, a8;
  logic [3:0] data4;
  logic       v4, a4;

  logic       rdy8, ld8, sin8, sout8, sd8, sv8, sl8, dn8, bz8;
  logic [7:0] d8;
  logic       rdy4, ld4, sin4, sout4, sd4, sv4, sl4, dn4, bz4;
  logic [3:0] d4;

  shift_register_tx_ctrl #(.BW_DATA(8), .FILL_BIT(1'b0)) dut8 (
    .i_Clk(clk), .i_Rst(rst), .i_Data(data8), .i_Valid(v8), .o_Ready(rdy8),
    .i_Abort(a8), .o_Load(ld8), .o_D(d8), .o_Sin(sin8), .i_Sout(sout8),
    .o_SerData(sd8), .o_SerValid(sv8), .o_SerLast(sl8), .o_Done(dn8), .o_Busy(bz8)
  );

  shift_register_tx_ctrl #(.BW_DATA(4), .FILL_BIT(1'b1)) dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_Data(data4), .i_Valid(v4), .o_Ready(rdy4),
    .i_Abort(a4), .o_Load(ld4), .o_D(d4), .o_Sin(sin4), .i_Sout(sout4),
    .o_SerData(sd4), .o_SerValid(sv4), .o_SerLast(sl4), .o_Done(dn4), .o_Busy(bz4)
  );

  // Free-running parallel-load shift registers. They load on Load and
  // otherwise shift toward the MSB. Sout is the MSB.
  logic [7:0] sr8;
  logic [3:0] sr4;
  always @(posedge clk) begin
    if (ld8) sr8 <= d8; else sr8 <= {sr8[6:0], sin8};
    if (ld4) sr4 <= d4; else sr4 <= {sr4[2:0], sin4};
  end
  assign sout8 = sr8[7];
  assign sout4 = sr4[3];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s inst%0d cyc %0d: got %0d expected %0d", nm, inst, cyc, act, exp);
  endtask

  // Expected-event schedule, indexed by [instance][cycle].
  localparam int NC = 1024;
  bit e_load [2][NC];
  bit e_sv   [2][NC];
  bit e_sd   [2][NC];
  bit e_last [2][NC];
  bit e_done [2][NC];
  bit e_busy [2][NC];
  int         freec [2];
  logic [7:0] e_d   [2];

  initial begin
    freec[0] = 0; freec[1] = 0;
    e_d[0] = '0;  e_d[1] = '0;
  end

  // Single compare process. It updates the model from this cycle's inputs
  // and then checks every output of both controllers.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int         w, t;
      logic       av, ab, exp_rdy;
      logic [7:0] dat;
      w   = (i == 0) ? 8 : 4;
      t   = cyc;
      av  = (i == 0) ? v8 : v4;
      ab  = (i == 0) ? a8 : a4;
      dat = (i == 0) ? data8 : {4'b0, data4};
      if (rst) begin
        for (int c = t; c < NC; c++) begin
          e_load[i][c] = 0; e_sv[i][c] = 0; e_sd[i][c] = 0;
          e_last[i][c] = 0; e_done[i][c] = 0; e_busy[i][c] = 0;
        end
        freec[i] = t;
        e_d[i]   = '0;
      end else if (ab) begin
        for (int c = t; c < NC; c++) begin
          e_sv[i][c] = 0; e_last[i][c] = 0;
          if (c > t) begin
            e_load[i][c] = 0; e_done[i][c] = 0; e_busy[i][c] = 0; e_sd[i][c] = 0;
          end
        end
        freec[i] = t;
      end
      exp_rdy = !ab && (t >= freec[i]);
      if (i == 0) begin
        chk("ready", 0, int'(rdy8), int'(exp_rdy));
        chk("load",  0, int'(ld8),  int'(e_load[0][t]));
        chk("d",     0, int'(d8),   int'(e_d[0]));
        chk("sin",   0, int'(sin8), 0);
        chk("busy",  0, int'(bz8),  int'(e_busy[0][t]));
        chk("done",  0, int'(dn8),  int'(e_done[0][t]));
        chk("serv",  0, int'(sv8),  int'(e_sv[0][t]));
        chk("serl",  0, int'(sl8),  int'(e_last[0][t]));
        if (e_sv[0][t]) chk("serd", 0, int'(sd8), int'(e_sd[0][t]));
      end else begin
        chk("ready", 1, int'(rdy4), int'(exp_rdy));
        chk("load",  1, int'(ld4),  int'(e_load[1][t]));
        chk("d",     1, int'(d4),   int'(e_d[1]));
        chk("sin",   1, int'(sin4), 1);
        chk("busy",  1, int'(bz4),  int'(e_busy[1][t]));
        chk("done",  1, int'(dn4),  int'(e_done[1][t]));
        chk("serv",  1, int'(sv4),  int'(e_sv[1][t]));
        chk("serl",  1, int'(sl4),  int'(e_last[1][t]));
        if (e_sv[1][t]) chk("serd", 1, int'(sd4), int'(e_sd[1][t]));
      end
      if (!rst && av && exp_rdy) begin
        e_d[i]          = dat;
        e_load[i][t+1]  = 1;
        for (int k = 0; k < w; k++) begin
          e_sv[i][t+2+k] = 1;
          e_sd[i][t+2+k] = dat[w-1-k];
        end
        for (int c = t + 1; c <= t + 1 + w; c++) e_busy[i][c] = 1;
        e_last[i][t+1+w] = 1;
        e_done[i][t+2+w] = 1;
        freec[i]         = t + 1 + w;
      end
    end
  end

  // Stream collectors used by the literal checks.
  logic [31:0] col8 = '0, col4 = '0;
  int n8 = 0, n4 = 0, nd8 = 0, nd4 = 0, dc8 = 0, dc4 = 0;
  always @(negedge clk) begin
    if (sv8) begin col8 <= {col8[30:0], sd8}; n8 <= n8 + 1; end
    if (sv4) begin col4 <= {col4[30:0], sd4}; n4 <= n4 + 1; end
    if (dn8) begin nd8 <= nd8 + 1; dc8 <= cyc; end
    if (dn4) begin nd4 <= nd4 + 1; dc4 <= cyc; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t0, bn, bd;

  initial begin
    rst = 1'b1; data8 = '0; v8 = 0; a8 = 0; data4 = '0; v4 = 0; a4 = 0;
    repeat (2) tick();
    chk("rst_ready", 0, int'(rdy8), 1);
    chk("rst_busy",  0, int'(bz8),  0);
    chk("rst_d",     0, int'(d8),   0);
    rst = 1'b0;
    repeat (2) tick();

    // Single word A5.
    bn = n8; bd = nd8; t0 = cyc;
    v8 = 1; data8 = 8'hA5;
    tick(); v8 = 0;
    repeat (12) tick();
    chk("t1_bits",  0, int'(col8[7:0]), 8'hA5);
    chk("t1_nbits", 0, n8 - bn, 8);
    chk("t1_ndone", 0, nd8 - bd, 1);
    chk("t1_donec", 0, dc8 - t0, 10);

    // Back-to-back A5 then 3C, valid held.
    bn = n8; bd = nd8; t0 = cyc;
    v8 = 1; data8 = 8'hA5;
    tick(); data8 = 8'h3C;
    repeat (8) tick();
    tick(); v8 = 0;
    repeat (12) tick();
    chk("t2_bits",  0, int'(col8[15:0]), 16'hA53C);
    chk("t2_nbits", 0, n8 - bn, 16);
    chk("t2_ndone", 0, nd8 - bd, 2);
    chk("t2_donec", 0, dc8 - t0, 19);

    // Stall: FF offered mid-word, taken only on the last-bit cycle.
    bn = n8; t0 = cyc;
    v8 = 1; data8 = 8'h55;
    tick(); v8 = 0;
    repeat (3) tick();
    v8 = 1; data8 = 8'hFF;
    #1 chk("t3_stall_rdy", 0, int'(rdy8), 0);
    repeat (5) tick();
    tick(); v8 = 0;
    repeat (12) tick();
    chk("t3_bits",  0, int'(col8[15:0]), 16'h55FF);
    chk("t3_nbits", 0, n8 - bn, 16);

    // Abort at the fourth serial bit, then a clean 81.
    bn = n8; bd = nd8;
    v8 = 1; data8 = 8'hA5;
    tick(); v8 = 0;
    repeat (4) tick();
    a8 = 1;
    #1 chk("t4_abort_sv", 0, int'(sv8), 0);
    tick(); a8 = 0;
    #1 chk("t4_idle_busy", 0, int'(bz8), 0);
    repeat (2) tick();
    v8 = 1; data8 = 8'h81;
    tick(); v8 = 0;
    repeat (12) tick();
    chk("t4_bits",  0, int'(col8[10:0]), 11'h581);
    chk("t4_nbits", 0, n8 - bn, 11);
    chk("t4_ndone", 0, nd8 - bd, 1);

    // Reset mid-word, then 5A completes normally.
    bn = n8; bd = nd8;
    v8 = 1; data8 = 8'hC3;
    tick(); v8 = 0;
    repeat (5) tick();
    #1 rst = 1'b1;
    #1;
    chk("t5_sv",   0, int'(sv8), 0);
    chk("t5_load", 0, int'(ld8), 0);
    chk("t5_done", 0, int'(dn8), 0);
    chk("t5_busy", 0, int'(bz8), 0);
    tick(); rst = 1'b0;
    tick();
    v8 = 1; data8 = 8'h5A;
    tick(); v8 = 0;
    repeat (12) tick();
    chk("t5_bits",  0, int'(col8[11:0]), 12'hC5A);
    chk("t5_nbits", 0, n8 - bn, 12);
    chk("t5_ndone", 0, nd8 - bd, 1);

    // Narrow instance with fill 1.
    bn = n4; bd = nd4; t0 = cyc;
    v4 = 1; data4 = 4'b1001;
    tick(); v4 = 0;
    repeat (8) tick();
    chk("t6_sin",   1, int'(sin4), 1);
    chk("t6_bits",  1, int'(col4[3:0]), 9);
    chk("t6_nbits", 1, n4 - bn, 4);
    chk("t6_ndone", 1, nd4 - bd, 1);
    chk("t6_donec", 1, dc4 - t0, 6);

    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
